gps_sentence_tx: RTL and testbench

GPS_SENTENCE_TX -- requirements
Module: gps_sentence_tx

---
 rtl/gps_pkg.sv | 41 ++++
 rtl/uart_tx_byte.sv | 55 +++++
 rtl/gps_sentence_tx.sv | 130 +++++++++++++
 tb/tb_gps_sentence_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_pkg.sv
// Shared constants, state encoding and helpers for the GPRMC sentence transmitter.
// NMEA_CHECKSUM_EN selects the 20-byte sentence with a "*CC" checksum field.
package gps_pkg;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 9600;

  localparam logic [7:0]  ASC_DOLLAR = 8'h24;
  localparam logic [7:0]  ASC_COMMA  = 8'h2C;
  localparam logic [7:0]  ASC_STAR   = 8'h2A;
  localparam logic [7:0]  ASC_A      = 8'h41;
  localparam logic [7:0]  ASC_CR     = 8'h0D;
  localparam logic [7:0]  ASC_LF     = 8'h0A;
  localparam logic [7:0]  ASC_ZERO   = 8'h30;
  localparam logic [39:0] ASC_GPRMC  = "GPRMC";

`ifdef NMEA_CHECKSUM_EN
  localparam int NUM_BYTES = 20;
`else
  localparam int NUM_BYTES = 17;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} tx_state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] tens_ascii(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return ASC_ZERO + {2'b00, t};
  endfunction

  function automatic logic [7:0] units_ascii(input logic [5:0] v);
    logic [5:0] u;
    u = v % 6'd10;
    return ASC_ZERO + {2'b00, u};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready rises during the final stop-bit clock so the next
// byte can be loaded on that edge, giving gapless back-to-back frames.
module uart_tx_byte
  import gps_pkg::*;
#(
  parameter int CPB = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

  logic          active;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] baud_cnt;
  logic          baud_end;

  assign baud_end = (baud_cnt == CW'(CPB - 1));
  assign ready    = !active || (bit_cnt == 4'd9 && baud_end);
  // Line is driven from the async-reset flag so reset raises it immediately.
  assign tx       = active ? shreg[0] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (load && ready) begin
      active   <= 1'b1;
      shreg    <= {1'b1, data, 1'b0};
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (active) begin
      if (baud_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gps_sentence_tx.sv
// Sends "$GPRMC,hhmmss,A[*CC]\r\n" over UART from latched GPS time fields.
// Define NMEA_CHECKSUM_EN to include the XOR checksum field.
module gps_sentence_tx
  import gps_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] gps_hr,
  input  logic [5:0] gps_min,
  input  logic [5:0] gps_sec,
  output logic       uart_tx_pin,
  output logic       busy,
  output logic       done
);

  localparam int         CPB      = CLK_FREQ / BAUD_RATE;
  localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);

  tx_state_t  state, next_state;
  logic [4:0] idx, tx_idx;
  logic [4:0] hr_q;
  logic [5:0] min_q, sec_q;
  logic [7:0] tx_byte;
  logic       ser_load, ser_ready;
`ifdef NMEA_CHECKSUM_EN
  logic [7:0] csum;
`endif

  uart_tx_byte #(.CPB(CPB)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .data  (tx_byte),
    .tx    (uart_tx_pin),
    .ready (ser_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ser_load   = 1'b0;
    tx_idx     = idx + 5'd1;
    case (state)
      ST_IDLE: if (start) next_state = ST_LOAD;
      ST_LOAD: begin
        ser_load   = 1'b1;
        tx_idx     = 5'd0;
        next_state = ST_SEND;
      end
      ST_SEND: if (ser_ready) begin
        if (idx == LAST_IDX) next_state = ST_DONE;
        else                 ser_load   = 1'b1;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    tx_byte = ASC_LF;
    case (tx_idx)
      5'd0:  tx_byte = ASC_DOLLAR;
      5'd1:  tx_byte = ASC_GPRMC[39:32];
      5'd2:  tx_byte = ASC_GPRMC[31:24];
      5'd3:  tx_byte = ASC_GPRMC[23:16];
      5'd4:  tx_byte = ASC_GPRMC[15:8];
      5'd5:  tx_byte = ASC_GPRMC[7:0];
      5'd6:  tx_byte = ASC_COMMA;
      5'd7:  tx_byte = tens_ascii({1'b0, hr_q});
      5'd8:  tx_byte = units_ascii({1'b0, hr_q});
      5'd9:  tx_byte = tens_ascii(min_q);
      5'd10: tx_byte = units_ascii(min_q);
      5'd11: tx_byte = tens_ascii(sec_q);
      5'd12: tx_byte = units_ascii(sec_q);
      5'd13: tx_byte = ASC_COMMA;
      5'd14: tx_byte = ASC_A;
`ifdef NMEA_CHECKSUM_EN
      5'd15: tx_byte = ASC_STAR;
      5'd16: tx_byte = hex_ascii(csum[7:4]);
      5'd17: tx_byte = hex_ascii(csum[3:0]);
      5'd18: tx_byte = ASC_CR;
      5'd19: tx_byte = ASC_LF;
`else
      5'd15: tx_byte = ASC_CR;
      5'd16: tx_byte = ASC_LF;
`endif
      default: tx_byte = ASC_LF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      hr_q  <= '0;
      min_q <= '0;
      sec_q <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        hr_q  <= gps_hr;
        min_q <= gps_min;
        sec_q <= gps_sec;
      end
      if (ser_load) idx <= tx_idx;
    end
  end

`ifdef NMEA_CHECKSUM_EN
  // XOR covers bytes 1..14 (between '$' and '*'), folded in as each is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (ser_load) begin
      if (state == ST_LOAD)                        csum <= '0;
      else if (tx_idx >= 5'd1 && tx_idx <= 5'd14)  csum <= csum ^ tx_byte;
    end
  end
`endif

endmodule

// File: tb/tb_gps_sentence_tx.sv
// Self-checking bench: UART line decoder plus a string-level sentence model.
module tb_gps_sentence_tx;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 250;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int FR        = 10 * CPB;
`ifdef NMEA_CHECKSUM_EN
  localparam int NB = 20;
`else
  localparam int NB = 17;
`endif

  logic       clk, rst, start;
  logic [4:0] gps_hr;
  logic [5:0] gps_min, gps_sec;
  logic       uart_tx_pin, busy, done;

  int         cyc;
  int         tests, fails;
  int         frame_err;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         fall_q[$];
  int         done_q[$];

  gps_sentence_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .gps_hr      (gps_hr),
    .gps_min     (gps_min),
    .gps_sec     (gps_sec),
    .uart_tx_pin (uart_tx_pin),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples every falling clock edge, mid-bit data capture.
  initial begin
    int         cnt;
    int         b;
    bit         act;
    logic [7:0] sh;
    act = 0; cnt = 0; sh = '0; frame_err = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_q.push_back(cyc);
      if (rst !== 1'b0) begin
        act = 0;
      end else if (!act) begin
        if (uart_tx_pin === 1'b0) begin
          act = 1; cnt = 0;
          fall_q.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          b = cnt / CPB;
          if (b >= 1 && b <= 8) sh[b-1] = uart_tx_pin;
          else if (b == 9) begin
            if (uart_tx_pin !== 1'b1) frame_err++;
            rx_q.push_back(sh);
          end
        end
        if (cnt == FR - 1) act = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Reference sentence built from the textual format rules.
  task automatic build_exp(input int h, input int m, input int s);
    string      hx;
    logic [7:0] x;
    hx = "0123456789ABCDEF";
    exp_q.delete();
    push_str("$GPRMC,");
    exp_q.push_back(8'(48 + h / 10)); exp_q.push_back(8'(48 + h % 10));
    exp_q.push_back(8'(48 + m / 10)); exp_q.push_back(8'(48 + m % 10));
    exp_q.push_back(8'(48 + s / 10)); exp_q.push_back(8'(48 + s % 10));
    push_str(",A");
`ifdef NMEA_CHECKSUM_EN
    x = '0;
    for (int i = 1; i < exp_q.size(); i++) x = x ^ exp_q[i];
    exp_q.push_back(8'h2A);
    exp_q.push_back(hx[int'(x[7:4])]);
    exp_q.push_back(hx[int'(x[3:0])]);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic chk_bytes(input string tag, input int reps);
    chk({tag, "_count"}, 32'(rx_q.size()), 32'(reps * NB));
    for (int i = 0; i < rx_q.size() && i < reps * NB; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i % NB]));
  endtask

  // One sentence; disturb >= 0 pulses start and scrambles inputs inside that byte.
  task automatic do_sentence(input string tag, input int h, input int m, input int s,
                             input int disturb);
    int load_c, t, busy_low;
    rx_q.delete(); fall_q.delete(); done_q.delete();
    @(negedge clk);
    gps_hr = 5'(h); gps_min = 6'(m); gps_sec = 6'(s);
    start = 1'b1;
    load_c = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_load"}, 32'(busy), 32'd1);
    t = 0; busy_low = 0;
    while (done_q.size() == 0 && t < NB * FR + 20) begin
      @(negedge clk);
      t++;
      if (busy !== 1'b1) busy_low++;
      if (disturb >= 0 && cyc == load_c + 1 + disturb * FR + 3) begin
        start   = 1'b1;
        gps_hr  = 5'($urandom);
        gps_min = 6'($urandom);
        gps_sec = 6'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0)
      chk({tag, "_done_latency"}, 32'(done_q[0] - load_c), 32'(NB * FR + 1));
    chk({tag, "_busy_held"}, 32'(busy_low), 32'd0);
    chk({tag, "_first_start_bit"}, (fall_q.size() > 0) ? 32'(fall_q[0] - load_c) : 32'hFFFF_FFFF,
        32'd1);
    repeat (2 * FR) @(negedge clk);
    chk({tag, "_single_done"}, 32'(done_q.size()), 32'd1);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk_bytes(tag, 1);
  endtask

  initial begin
    int load_c, t;
    tests = 0; fails = 0; cyc = 0;
    rst = 1'b1; start = 1'b0;
    gps_hr = '0; gps_min = '0; gps_sec = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(uart_tx_pin), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed sentence against a literal expectation.
    exp_q.delete();
`ifdef NMEA_CHECKSUM_EN
    push_str("$GPRMC,123519,A*07\r\n");
`else
    push_str("$GPRMC,123519,A\r\n");
`endif
    do_sentence("directed", 12, 35, 19, -1);

    build_exp(0, 0, 0);
    do_sentence("zeros", 0, 0, 0, -1);
    build_exp(31, 63, 63);
    do_sentence("max", 31, 63, 63, -1);

    // Start and input change during byte 5 must not disturb the sentence.
    build_exp(7, 42, 58);
    do_sentence("ignore_start", 7, 42, 58, 5);

    // Reset during data bit 0 of byte 8 ('2', a 0 bit).
    rx_q.delete(); fall_q.delete(); done_q.delete();
    @(negedge clk);
    gps_hr = 5'd12; gps_min = 6'd35; gps_sec = 6'd19; start = 1'b1;
    load_c = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (cyc < load_c + 1 + 8 * FR + CPB + 1 && t < NB * FR) begin
      @(negedge clk);
      t++;
    end
    chk("abort_pre_line", 32'(uart_tx_pin), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_tx_high", 32'(uart_tx_pin), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FR) @(negedge clk);
    chk("abort_no_done", 32'(done_q.size()), 32'd0);
    build_exp(12, 35, 19);
    do_sentence("after_abort", 12, 35, 19, -1);

    // start held high: back-to-back sentences, relaunch on first IDLE cycle.
    build_exp(23, 59, 1);
    rx_q.delete(); fall_q.delete(); done_q.delete();
    @(negedge clk);
    gps_hr = 5'd23; gps_min = 6'd59; gps_sec = 6'd1; start = 1'b1;
    t = 0;
    while (fall_q.size() <= NB && t < 2 * NB * FR + 40) begin
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (done_q.size() > 0 && fall_q.size() > NB)
      chk("held_restart", 32'(fall_q[NB] - done_q[0]), 32'd3);
    else
      chk("held_restart_seen", 32'(fall_q.size()), 32'(NB + 1));
    t = 0;
    while (done_q.size() < 2 && t < NB * FR + 40) begin
      @(negedge clk);
      t++;
    end
    chk("held_two_done", 32'(done_q.size()), 32'd2);
    if (done_q.size() >= 2)
      chk("held_done_spacing", 32'(done_q[1] - done_q[0]), 32'(NB * FR + 3));
    repeat (2 * FR) @(negedge clk);
    chk_bytes("held", 2);

    for (int k = 0; k < 5; k++) begin
      int h, m, s;
      h = int'($urandom_range(0, 31));
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      build_exp(h, m, s);
      do_sentence($sformatf("rand%0d", k), h, m, s, -1);
    end

    chk("frame_errors", 32'(frame_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
